// File: rtl/rintaro_irq_pkg.sv
// Shared constants for the interrupt event queue: FSM state encodings,
// default key FIFO depth and the padding applied to 9-bit scancodes.
package rintaro_irq_pkg;

  localparam int unsigned IRQ_FIFO_DEPTH_DEFAULT = 8;
  localparam int unsigned STATE_W                = 2;

  localparam logic [6:0] KEY_PAD = 7'b0;

  // FSM state encodings
  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_ASSERT  = 2'd1;
  localparam logic [STATE_W-1:0] ST_RELEASE = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     write request / data (accepted when not full, or when full
//                 and popping in the same cycle)
//   pop           read request (ignored when empty)
//   dout          head entry, valid while not empty
//   full, empty   status flags
//   count         number of stored entries
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/irq_event_queue.sv
// Interrupt event queue: buffers keyboard key events in a FIFO and holds one
// breakpoint hit, presenting one event at a time as a held irq until the CPU
// acknowledges through turnOffIRQ (ack). Breakpoints take priority over keys.
// Ports:
//   fastClk, rst  clock, synchronous active-high reset
//   keyCode       9-bit scancode, stable while keyPressed is high
//   keyPressed    key level; rising edge is one event
//   keyEnable     key events dropped while low
//   bpAsync       breakpoint hit level from another clock domain
//   bpData        breakpoint payload
//   vectorIn      interrupt vector captured with each presented event
//   ack           acknowledge level from another clock domain
//   irq           held interrupt request
//   intData       payload of the presented event
//   intAddr       vector captured with the presented event
//   pending       queued key events, excluding the presented one
//   overflow      sticky: a key event was dropped on a full FIFO
module irq_event_queue
  import rintaro_irq_pkg::*;
#(
  parameter int unsigned DEPTH = IRQ_FIFO_DEPTH_DEFAULT,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          fastClk,
  input  logic          rst,
  input  logic [8:0]    keyCode,
  input  logic          keyPressed,
  input  logic          keyEnable,
  input  logic          bpAsync,
  input  logic [15:0]   bpData,
  input  logic [31:0]   vectorIn,
  input  logic          ack,
  output logic          irq,
  output logic [15:0]   intData,
  output logic [31:0]   intAddr,
  output logic [CW-1:0] pending,
  output logic          overflow
);

  logic               key_prev;
  logic               key_edge;
  logic               bp_s0, bp_s1, bp_s2;
  logic               bp_edge;
  logic               bp_pend;
  logic [15:0]        bp_buf;
  logic               ack_a0, ack_a1, ack_a2;
  logic               ack_edge;
  logic [STATE_W-1:0] state, state_next;
  logic               load_bp;
  logic               load_key;
  logic [15:0]        fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;

  assign key_edge = keyPressed & ~key_prev & keyEnable;
  assign bp_edge  = bp_s1 & ~bp_s2;
  assign ack_edge = ack_a1 & ~ack_a2;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_key_fifo (
    .clk   (fastClk),
    .rst   (rst),
    .push  (key_edge),
    .pop   (load_key),
    .din   ({KEY_PAD, keyCode}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  // Edge detect, synchronizers and the single-entry breakpoint slot
  always_ff @(posedge fastClk) begin
    if (rst) begin
      key_prev <= 1'b0;
      bp_s0    <= 1'b0;
      bp_s1    <= 1'b0;
      bp_s2    <= 1'b0;
      ack_a0   <= 1'b0;
      ack_a1   <= 1'b0;
      ack_a2   <= 1'b0;
      bp_pend  <= 1'b0;
      bp_buf   <= '0;
      overflow <= 1'b0;
    end else begin
      key_prev <= keyPressed;
      bp_s0    <= bpAsync;
      bp_s1    <= bp_s0;
      bp_s2    <= bp_s1;
      ack_a0   <= ack;
      ack_a1   <= ack_a0;
      ack_a2   <= ack_a1;
      // A fresh hit wins over the load that consumes the previous one.
      if (bp_edge) begin
        bp_pend <= 1'b1;
        bp_buf  <= bpData;
      end else if (load_bp) begin
        bp_pend <= 1'b0;
      end
      if (key_edge && fifo_full && !load_key) overflow <= 1'b1;
    end
  end

  // FSM state and presented-event registers
  always_ff @(posedge fastClk) begin
    if (rst) begin
      state   <= ST_IDLE;
      irq     <= 1'b0;
      intData <= '0;
      intAddr <= '0;
    end else begin
      state <= state_next;
      irq   <= (state_next == ST_ASSERT);
      if (load_bp) begin
        intData <= bp_buf;
        intAddr <= vectorIn;
      end else if (load_key) begin
        intData <= fifo_dout;
        intAddr <= vectorIn;
      end
    end
  end

  // Next-state: present an event from IDLE, wait for ack, wait for ack release
  always_comb begin
    state_next = state;
    load_bp    = 1'b0;
    load_key   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bp_pend) begin
          load_bp    = 1'b1;
          state_next = ST_ASSERT;
        end else if (!fifo_empty) begin
          load_key   = 1'b1;
          state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (ack_edge) state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!ack_a1) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_event_queue.sv
// Self-checking bench for irq_event_queue: directed scenarios followed by a
// randomized phase, all checked against a transaction-level queue model.
module tb_irq_event_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          fastClk = 1'b0;
  logic          rst;
  logic [8:0]    keyCode;
  logic          keyPressed;
  logic          keyEnable;
  logic          bpAsync;
  logic [15:0]   bpData;
  logic [31:0]   vectorIn;
  logic          ack;
  logic          irq;
  logic [15:0]   intData;
  logic [31:0]   intAddr;
  logic [CW-1:0] pending;
  logic          overflow;

  always #5 fastClk = ~fastClk;

  irq_event_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .fastClk    (fastClk),
    .rst        (rst),
    .keyCode    (keyCode),
    .keyPressed (keyPressed),
    .keyEnable  (keyEnable),
    .bpAsync    (bpAsync),
    .bpData     (bpData),
    .vectorIn   (vectorIn),
    .ack        (ack),
    .irq        (irq),
    .intData    (intData),
    .intAddr    (intAddr),
    .pending    (pending),
    .overflow   (overflow)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queued key payloads, one breakpoint slot, sticky overflow
  logic [15:0] key_q[$];
  bit          bp_pend_m;
  logic [15:0] bp_val_m;
  bit          busy;
  bit          exp_ovf;

  task automatic tick();
    @(posedge fastClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_irq(input logic lvl, input string tag);
    int n = 0;
    while (irq !== lvl && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(irq), 32'(lvl));
  endtask

  task automatic key_pulse(input logic [8:0] code, input logic en);
    keyCode    = code;
    keyEnable  = en;
    keyPressed = 1'b1;
    tick();
    keyPressed = 1'b0;
    tick();
  endtask

  // Key pressed while an event is already presented: goes to the queue
  task automatic key_queued(input logic [8:0] code, input logic en);
    key_pulse(code, en);
    if (en) begin
      if (key_q.size() < DEPTH) key_q.push_back({7'b0, code});
      else exp_ovf = 1'b1;
    end
  endtask

  // Key pressed while idle with nothing queued: presented two cycles later
  task automatic key_to_idle(input logic [8:0] code);
    vectorIn = $urandom;
    key_pulse(code, 1'b1);
    check("idle_key_irq", 32'(irq), 32'd1);
    check("idle_key_data", 32'(intData), {16'h0, 7'b0, code});
    check("idle_key_addr", intAddr, vectorIn);
    busy = 1'b1;
  endtask

  task automatic bp_hit(input logic [15:0] data);
    bpData  = data;
    bpAsync = 1'b1;
    repeat (6) tick();
    bpAsync = 1'b0;
    repeat (2) tick();
    bp_pend_m = 1'b1;
    bp_val_m  = data;
  endtask

  task automatic ack_raise();
    ack = 1'b1;
    wait_irq(1'b0, "irq_drop_on_ack");
  endtask

  // Release ack and expect the model's next event, or silence if none
  task automatic ack_release_expect();
    logic [15:0] exp_data;
    bit          hi;
    ack      = 1'b0;
    vectorIn = $urandom;
    if (bp_pend_m || key_q.size() > 0) begin
      if (bp_pend_m) begin
        exp_data  = bp_val_m;
        bp_pend_m = 1'b0;
      end else begin
        exp_data = key_q.pop_front();
      end
      wait_irq(1'b1, "next_irq");
      check("next_data", 32'(intData), 32'(exp_data));
      check("next_addr", intAddr, vectorIn);
      check("next_pending", 32'(pending), 32'(key_q.size()));
    end else begin
      hi = 1'b0;
      repeat (12) begin
        tick();
        if (irq !== 1'b0) hi = 1'b1;
      end
      check("stay_low", 32'(hi), 32'd0);
      check("idle_pending", 32'(pending), 32'd0);
      busy = 1'b0;
    end
  endtask

  task automatic ack_round();
    ack_raise();
    ack_release_expect();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hi;
    rst        = 1'b1;
    keyCode    = '0;
    keyPressed = 1'b0;
    keyEnable  = 1'b1;
    bpAsync    = 1'b0;
    bpData     = '0;
    vectorIn   = '0;
    ack        = 1'b0;
    bp_pend_m  = 1'b0;
    bp_val_m   = '0;
    busy       = 1'b0;
    exp_ovf    = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset values
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_data", 32'(intData), 32'd0);
    check("rst_addr", intAddr, 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single key with exact latencies
    vectorIn   = 32'h1000_0040;
    keyCode    = 9'h01C;
    keyPressed = 1'b1;
    tick();
    check("key_lat_irq_lo", 32'(irq), 32'd0);
    check("key_lat_pending", 32'(pending), 32'd1);
    keyPressed = 1'b0;
    tick();
    check("key_lat_irq_hi", 32'(irq), 32'd1);
    check("key_data", 32'(intData), 32'h001C);
    check("key_addr", intAddr, 32'h1000_0040);
    ack = 1'b1;
    repeat (2) tick();
    check("ack_lat_hold", 32'(irq), 32'd1);
    tick();
    check("ack_lat_fall", 32'(irq), 32'd0);
    ack = 1'b0;
    repeat (3) tick();
    check("after_ack_irq", 32'(irq), 32'd0);
    check("after_ack_data_held", 32'(intData), 32'h001C);

    // Burst of three keys
    key_to_idle(9'h015);
    key_queued(9'h01D, 1'b1);
    key_queued(9'h024, 1'b1);
    check("burst_pending", 32'(pending), 32'd2);
    check("burst_first", 32'(intData), 32'h0015);
    repeat (3) ack_round();

    // Overflow: ten edges while an event is held
    key_to_idle(9'h050);
    for (int i = 0; i < 10; i++) key_queued(9'(9'h060 + i), 1'b1);
    check("ovf_flag", 32'(overflow), 32'(exp_ovf));
    check("ovf_pending", 32'(pending), 32'd8);
    repeat (9) ack_round();

    // Breakpoint latency from idle
    bpData  = 16'h1234;
    bpAsync = 1'b1;
    repeat (3) tick();
    check("bp_lat_lo", 32'(irq), 32'd0);
    tick();
    check("bp_lat_hi", 32'(irq), 32'd1);
    check("bp_data", 32'(intData), 32'h1234);
    bpAsync = 1'b0;
    busy    = 1'b1;
    ack_round();

    // Breakpoint overtakes queued keys
    key_to_idle(9'h031);
    key_queued(9'h032, 1'b1);
    key_queued(9'h033, 1'b1);
    bp_hit(16'hBEEF);
    check("prio_irq_held", 32'(irq), 32'd1);
    check("prio_pending", 32'(pending), 32'd2);
    repeat (4) ack_round();

    // Ack held high through release; disabled keys ignored
    key_to_idle(9'h041);
    key_queued(9'h042, 1'b1);
    ack_raise();
    hi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key_queued(9'(9'h043 + i), 1'b0);
      if (irq !== 1'b0) hi = 1'b1;
    end
    check("ack_held_low", 32'(hi), 32'd0);
    check("ack_held_pending", 32'(pending), 32'd1);
    ack_release_expect();
    ack_round();

    // Reset while asserted with a queued key
    key_to_idle(9'h051);
    key_queued(9'h052, 1'b1);
    check("pre_rst_ovf", 32'(overflow), 32'(exp_ovf));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_data", 32'(intData), 32'd0);
    key_q.delete();
    bp_pend_m = 1'b0;
    busy      = 1'b0;
    exp_ovf   = 1'b0;
    repeat (3) tick();
    check("post_rst_quiet", 32'(irq), 32'd0);

    // Randomized traffic against the model
    key_to_idle(9'($urandom_range(0, 511)));
    for (int r = 0; r < 40; r++) begin
      int nk;
      nk = int'($urandom_range(0, 4));
      for (int k = 0; k < nk; k++)
        key_queued(9'($urandom_range(0, 511)), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 4) == 0) bp_hit(16'($urandom));
      check("rnd_pending", 32'(pending), 32'(key_q.size()));
      ack_round();
      if (!busy) key_to_idle(9'($urandom_range(0, 511)));
    end
    check("rnd_overflow", 32'(overflow), 32'(exp_ovf));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
